// File: rtl/rxiod_align_pkg.sv
// Shared types and default constants for the RX IOD eye-tap aligner.
// Imported by the interface users, the top and the window tracker.
package rxiod_align_pkg;

    localparam int NUM_TAPS_DEF      = 128;
    localparam int SETTLE_CYCLES_DEF = 8;
    localparam int SAMPLE_CYCLES_DEF = 64;
    localparam int MIN_WIN_DEF       = 4;
    localparam int TAP_W_DEF         = $clog2(NUM_TAPS_DEF) + 1;

    typedef logic [TAP_W_DEF-1:0] tap_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_SETTLE,
        S_SAMPLE,
        S_EVAL,
        S_STEP,
        S_CALC,
        S_RETURN,
        S_DONE,
        S_ERR
    } align_state_e;

endpackage

// File: rtl/rxiod_eye_tap_align_if.sv
// Control, status and IOD-side signals of one aligner lane.
// slave is the aligner side, master is the controller/IOD side.
interface rxiod_eye_tap_align_if #(
    parameter int TAP_W = 8
);

    logic             START;
    logic             EYE_MONITOR_EARLY;
    logic             EYE_MONITOR_LATE;
    logic             DELAY_LINE_OUT_OF_RANGE;
    logic             EYE_MONITOR_CLEAR_FLAGS;
    logic             DELAY_LINE_LOAD;
    logic             DELAY_LINE_MOVE;
    logic             DELAY_LINE_DIRECTION;
    logic             BUSY;
    logic             ALIGN_DONE;
    logic             ALIGN_ERR;
    logic [TAP_W-1:0] TAP_CUR;
    logic [TAP_W-1:0] WIN_START;
    logic [TAP_W-1:0] WIN_LEN;

    modport slave (
        input  START,
        input  EYE_MONITOR_EARLY,
        input  EYE_MONITOR_LATE,
        input  DELAY_LINE_OUT_OF_RANGE,
        output EYE_MONITOR_CLEAR_FLAGS,
        output DELAY_LINE_LOAD,
        output DELAY_LINE_MOVE,
        output DELAY_LINE_DIRECTION,
        output BUSY,
        output ALIGN_DONE,
        output ALIGN_ERR,
        output TAP_CUR,
        output WIN_START,
        output WIN_LEN
    );

    modport master (
        output START,
        output EYE_MONITOR_EARLY,
        output EYE_MONITOR_LATE,
        output DELAY_LINE_OUT_OF_RANGE,
        input  EYE_MONITOR_CLEAR_FLAGS,
        input  DELAY_LINE_LOAD,
        input  DELAY_LINE_MOVE,
        input  DELAY_LINE_DIRECTION,
        input  BUSY,
        input  ALIGN_DONE,
        input  ALIGN_ERR,
        input  TAP_CUR,
        input  WIN_START,
        input  WIN_LEN
    );

endinterface

// File: rtl/rxiod_eye_window_tracker.sv
// Run-length tracker: longest contiguous clean tap window seen so far.
// Ties keep the earliest window because replacement needs a strictly longer run.
module rxiod_eye_window_tracker
    import rxiod_align_pkg::*;
#(
    parameter int TAP_W = TAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             valid,
    input  logic             dirty,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [TAP_W-1:0] best_len
);

    logic [TAP_W-1:0] r_cur_start;
    logic [TAP_W-1:0] r_cur_len;
    logic [TAP_W-1:0] r_best_start;
    logic [TAP_W-1:0] r_best_len;
    logic [TAP_W-1:0] w_run_len;

    assign w_run_len  = r_cur_len + TAP_W'(1);
    assign best_start = r_best_start;
    assign best_len   = r_best_len;

    // Extend or restart the current run per evaluated tap, promote longer runs.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (valid) begin
            if (dirty) begin
                r_cur_len   <= '0;
                r_cur_start <= tap + TAP_W'(1);
            end else begin
                r_cur_len <= w_run_len;
                if (w_run_len > r_best_len) begin
                    r_best_start <= r_cur_start;
                    r_best_len   <= w_run_len;
                end
            end
        end
    end

endmodule

// File: rtl/rxiod_eye_tap_align.sv
// Sweeps the RX IOD delay line over every tap, scores each tap with the
// eye monitor, then walks back to the centre of the longest clean window.
module rxiod_eye_tap_align
    import rxiod_align_pkg::*;
#(
    parameter int NUM_TAPS      = NUM_TAPS_DEF,
    parameter int TAP_W         = $clog2(NUM_TAPS) + 1,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
    parameter int MIN_WIN       = MIN_WIN_DEF
) (
    input  logic                  FAB_CLK,
    input  logic                  RESET_N,
    rxiod_eye_tap_align_if.slave  bus
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ?
                             SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_END = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] LAST_TAP   = TAP_W'(NUM_TAPS - 1);
    localparam logic [TAP_W-1:0] MIN_LEN    = TAP_W'(MIN_WIN);

    align_state_e     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dirty;
    logic [TAP_W-1:0] r_tap;
    logic [TAP_W-1:0] r_rem;
    logic             r_clr;
    logic             r_load;
    logic             r_move;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_oor;
    logic             w_flag;
    logic             w_trk_clr;
    logic             w_trk_valid;
    logic [TAP_W-1:0] w_best_start;
    logic [TAP_W-1:0] w_best_len;
    logic [TAP_W-1:0] w_center;
    logic [TAP_W-1:0] w_remaining;
    logic             w_too_short;

    assign w_oor       = bus.DELAY_LINE_OUT_OF_RANGE;
    assign w_flag      = bus.EYE_MONITOR_EARLY | bus.EYE_MONITOR_LATE;
    assign w_trk_clr   = (r_state == S_LOAD);
    assign w_trk_valid = (r_state == S_EVAL);

    // Floor centre of the best window and the decrement count to reach it.
    assign w_center    = w_best_start + ((w_best_len - TAP_W'(1)) >> 1);
    assign w_remaining = LAST_TAP - w_center;
    assign w_too_short = (w_best_len == '0) || (w_best_len < MIN_LEN);

    rxiod_eye_window_tracker #(
        .TAP_W (TAP_W)
    ) u_tracker (
        .clk        (FAB_CLK),
        .rst_n      (RESET_N),
        .clr        (w_trk_clr),
        .valid      (w_trk_valid),
        .dirty      (r_dirty),
        .tap        (r_tap),
        .best_start (w_best_start),
        .best_len   (w_best_len)
    );

    assign bus.EYE_MONITOR_CLEAR_FLAGS = r_clr;
    assign bus.DELAY_LINE_LOAD         = r_load;
    assign bus.DELAY_LINE_MOVE         = r_move;
    assign bus.DELAY_LINE_DIRECTION    = r_dir;
    assign bus.BUSY                    = r_busy;
    assign bus.ALIGN_DONE              = r_done;
    assign bus.ALIGN_ERR               = r_err;
    assign bus.TAP_CUR                 = r_tap;
    assign bus.WIN_START               = w_best_start;
    assign bus.WIN_LEN                 = w_best_len;

    // Sweep/return sequencer; IOD pulses are registered on entry to their state.
    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dirty <= 1'b0;
            r_tap   <= '0;
            r_rem   <= '0;
            r_clr   <= 1'b0;
            r_load  <= 1'b0;
            r_move  <= 1'b0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_clr  <= 1'b0;
            r_load <= 1'b0;
            r_move <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.START) begin
                        r_state <= S_LOAD;
                        r_load  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_tap   <= '0;
                    end
                end
                S_LOAD: begin
                    r_state <= S_CLR;
                    r_clr   <= 1'b1;
                end
                S_CLR: begin
                    r_state <= S_SETTLE;
                    r_cnt   <= '0;
                    r_dirty <= 1'b0;
                end
                S_SETTLE: begin
                    if (w_oor) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == SETTLE_END) begin
                        r_state <= S_SAMPLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (w_oor) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_dirty <= r_dirty | w_flag;
                        if (r_cnt == SAMPLE_END) begin
                            r_state <= S_EVAL;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_EVAL: begin
                    if (r_tap == LAST_TAP) begin
                        r_state <= S_CALC;
                    end else begin
                        r_state <= S_STEP;
                        r_move  <= 1'b1;
                        r_dir   <= 1'b1;
                        r_tap   <= r_tap + TAP_W'(1);
                    end
                end
                S_STEP: begin
                    if (w_oor) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_CLR;
                        r_clr   <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (w_too_short) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_remaining == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_RETURN;
                        r_move  <= 1'b1;
                        r_dir   <= 1'b0;
                        r_tap   <= r_tap - TAP_W'(1);
                        r_rem   <= w_remaining - TAP_W'(1);
                    end
                end
                S_RETURN: begin
                    // r_move high marks the pulse half; the next cycle is idle.
                    if (w_oor) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_move) begin
                        r_state <= S_RETURN;
                    end else if (r_rem == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_move <= 1'b1;
                        r_dir  <= 1'b0;
                        r_tap  <= r_tap - TAP_W'(1);
                        r_rem  <= r_rem - TAP_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rxiod_eye_tap_align.sv
// Bench for rxiod_eye_tap_align: IOD eye model plus a cycle-timeline reference
// derived from the tap map, checked on every cycle of each alignment run.
module tb_rxiod_eye_tap_align;

    localparam int NT = 128;
    localparam int TW = 8;
    localparam int S  = 4;
    localparam int N  = 8;
    localparam int MW = 4;
    localparam int P  = S + N + 3;
    localparam int CALC_R = NT * P + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rxiod_eye_tap_align_if #(.TAP_W(TW)) bus ();

    rxiod_eye_tap_align #(
        .NUM_TAPS      (NT),
        .TAP_W         (TW),
        .SETTLE_CYCLES (S),
        .SAMPLE_CYCLES (N),
        .MIN_WIN       (MW)
    ) dut (
        .FAB_CLK (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit dmap [NT];
    int oor_tap = -1;
    int e_start, e_len, e_center, e_rem, term_r;
    bit e_fail;
    bit run_active = 0;
    int run_r = -1;
    int dec_cnt = 0;
    int last_dec = 0;
    int iod_tap = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d want %0d (r=%0d t=%0t)",
                         nm, act, exp, run_r, $time);
        end
    endtask

    // Longest clean run among taps [0,n), earliest wins on ties.
    task automatic best_win(input int n, output int bs, output int bl);
        bs = 0;
        bl = 0;
        for (int s = 0; s < n; s++) begin
            if (!dmap[s] && (s == 0 || dmap[s > 0 ? s - 1 : 0])) begin
                int l = 0;
                while (s + l < n && !dmap[s + l]) l++;
                if (l > bl) begin
                    bl = l;
                    bs = s;
                end
            end
        end
    endtask

    task automatic set_model();
        best_win(oor_tap >= 0 ? oor_tap : NT, e_start, e_len);
        e_fail   = (e_len < MW) || (e_len == 0);
        e_center = (e_len > 0) ? e_start + (e_len - 1) / 2 : 0;
        e_rem    = NT - 1 - e_center;
        if (oor_tap >= 0)
            term_r = 2 + oor_tap * P + 2;
        else if (e_fail)
            term_r = CALC_R + 1;
        else
            term_r = CALC_R + 1 + 2 * e_rem;
    endtask

    // Expected outputs for cycle r after START acceptance (r=1 is LOAD).
    task automatic check_cycle(input int r);
        logic eld, eclr, emv, edir, ebusy, edone, eerr;
        int etap, k, o, j;
        bit tap_care, win_care;
        eld = 0; eclr = 0; emv = 0; edir = 0;
        ebusy = 0; edone = 0; eerr = 0;
        etap = 0; tap_care = 1; win_care = 0;
        if (r >= term_r) begin
            if (oor_tap >= 0 || e_fail) eerr = 1;
            else edone = 1;
            etap = (oor_tap >= 0) ? oor_tap : (e_fail ? NT - 1 : e_center);
            win_care = 1;
        end else if (r == 1) begin
            eld = 1;
            ebusy = 1;
        end else if (r < CALC_R) begin
            k = (r - 2) / P;
            o = (r - 2) % P;
            ebusy = 1;
            eclr = (o == 0);
            emv = (o == S + N + 2);
            edir = 1;
            etap = k;
            tap_care = !emv;
        end else if (r == CALC_R) begin
            ebusy = 1;
            etap = NT - 1;
        end else begin
            j = r - CALC_R - 1;
            ebusy = 1;
            emv = (j % 2 == 0);
            etap = NT - 1 - (j / 2 + 1);
            tap_care = !emv;
        end
        chk("LOAD", 32'(bus.DELAY_LINE_LOAD), 32'(eld));
        chk("CLEAR", 32'(bus.EYE_MONITOR_CLEAR_FLAGS), 32'(eclr));
        chk("MOVE", 32'(bus.DELAY_LINE_MOVE), 32'(emv));
        chk("BUSY", 32'(bus.BUSY), 32'(ebusy));
        chk("DONE", 32'(bus.ALIGN_DONE), 32'(edone));
        chk("ERR", 32'(bus.ALIGN_ERR), 32'(eerr));
        if (emv) chk("DIR", 32'(bus.DELAY_LINE_DIRECTION), 32'(edir));
        if (tap_care) chk("TAP_CUR", 32'(bus.TAP_CUR), 32'(etap));
        if (win_care) begin
            chk("WIN_START", 32'(bus.WIN_START), 32'(e_start));
            chk("WIN_LEN", 32'(bus.WIN_LEN), 32'(e_len));
        end
    endtask

    // Per-cycle compare against the timeline model.
    initial begin
        forever begin
            @(negedge clk);
            if (!run_active) begin
                run_r = -1;
                dec_cnt = 0;
            end else begin
                run_r++;
                if (run_r >= 1) begin
                    check_cycle(run_r);
                    if (bus.DELAY_LINE_MOVE && !bus.DELAY_LINE_DIRECTION)
                        dec_cnt++;
                end
            end
        end
    end

    // IOD model: tracks the delay tap from LOAD/MOVE, flags dirty taps,
    // and injects random flag noise during the settle window after a clear.
    initial begin
        logic lld, lmv, ldir, lclr;
        logic [1:0] v;
        int noise;
        noise = 0;
        bus.EYE_MONITOR_EARLY = 1'b0;
        bus.EYE_MONITOR_LATE = 1'b0;
        bus.DELAY_LINE_OUT_OF_RANGE = 1'b0;
        forever begin
            @(negedge clk);
            lld = bus.DELAY_LINE_LOAD;
            lmv = bus.DELAY_LINE_MOVE;
            ldir = bus.DELAY_LINE_DIRECTION;
            lclr = bus.EYE_MONITOR_CLEAR_FLAGS;
            @(posedge clk);
            #1;
            if (lld) iod_tap = 0;
            else if (lmv) iod_tap = ldir ? iod_tap + 1 : iod_tap - 1;
            if (iod_tap < 0) iod_tap = 0;
            if (iod_tap > NT - 1) iod_tap = NT - 1;
            if (lclr) noise = S;
            if (noise > 0) begin
                noise--;
                v = 2'($urandom_range(0, 3));
            end else if (dmap[iod_tap]) begin
                v = 2'($urandom_range(1, 3));
            end else begin
                v = 2'b00;
            end
            bus.EYE_MONITOR_EARLY = v[0];
            bus.EYE_MONITOR_LATE = v[1];
            bus.DELAY_LINE_OUT_OF_RANGE = (oor_tap >= 0 && iod_tap == oor_tap);
        end
    end

    task automatic run(input bit poke);
        set_model();
        @(posedge clk);
        #1;
        bus.START = 1'b1;
        run_active = 1'b1;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        while (run_r < term_r + 3) begin
            @(posedge clk);
            #1;
            bus.START = (poke && run_r == 300);
        end
        bus.START = 1'b0;
        last_dec = dec_cnt;
        run_active = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_LOAD"}, 32'(bus.DELAY_LINE_LOAD), 0);
        chk({tag, "_CLEAR"}, 32'(bus.EYE_MONITOR_CLEAR_FLAGS), 0);
        chk({tag, "_MOVE"}, 32'(bus.DELAY_LINE_MOVE), 0);
        chk({tag, "_DIR"}, 32'(bus.DELAY_LINE_DIRECTION), 0);
        chk({tag, "_BUSY"}, 32'(bus.BUSY), 0);
        chk({tag, "_DONE"}, 32'(bus.ALIGN_DONE), 0);
        chk({tag, "_ERR"}, 32'(bus.ALIGN_ERR), 0);
        chk({tag, "_TAP"}, 32'(bus.TAP_CUR), 0);
        chk({tag, "_WSTART"}, 32'(bus.WIN_START), 0);
        chk({tag, "_WLEN"}, 32'(bus.WIN_LEN), 0);
    endtask

    task automatic map_fill(input bit val);
        for (int i = 0; i < NT; i++) dmap[i] = val;
    endtask

    task automatic map_case2();
        for (int i = 0; i < NT; i++) dmap[i] = (i < 20) || (i >= 60);
    endtask

    task automatic chk_case2(input string tag);
        chk({tag, "_WSTART"}, 32'(bus.WIN_START), 20);
        chk({tag, "_WLEN"}, 32'(bus.WIN_LEN), 40);
        chk({tag, "_TAP"}, 32'(bus.TAP_CUR), 39);
        chk({tag, "_DECS"}, 32'(last_dec), 88);
        chk({tag, "_DONE"}, 32'(bus.ALIGN_DONE), 1);
    endtask

    initial begin
        bus.START = 1'b0;
        map_fill(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        map_fill(1'b0);
        run(1'b0);
        chk("clean_WSTART", 32'(bus.WIN_START), 0);
        chk("clean_WLEN", 32'(bus.WIN_LEN), 128);
        chk("clean_TAP", 32'(bus.TAP_CUR), 63);
        chk("clean_DECS", 32'(last_dec), 64);
        chk("clean_DONE", 32'(bus.ALIGN_DONE), 1);

        map_case2();
        run(1'b1);
        chk_case2("mid");

        map_fill(1'b1);
        for (int i = 10; i < 20; i++) dmap[i] = 1'b0;
        for (int i = 70; i < 80; i++) dmap[i] = 1'b0;
        run(1'b0);
        chk("tie_WSTART", 32'(bus.WIN_START), 10);
        chk("tie_WLEN", 32'(bus.WIN_LEN), 10);
        chk("tie_TAP", 32'(bus.TAP_CUR), 14);

        map_fill(1'b1);
        for (int i = 30; i < 33; i++) dmap[i] = 1'b0;
        run(1'b0);
        chk("short_WLEN", 32'(bus.WIN_LEN), 3);
        chk("short_ERR", 32'(bus.ALIGN_ERR), 1);
        chk("short_DONE", 32'(bus.ALIGN_DONE), 0);
        chk("short_DECS", 32'(last_dec), 0);

        map_fill(1'b0);
        oor_tap = 50;
        run(1'b0);
        chk("oor_ERR", 32'(bus.ALIGN_ERR), 1);
        chk("oor_BUSY", 32'(bus.BUSY), 0);
        chk("oor_TAP", 32'(bus.TAP_CUR), 50);
        chk("oor_WLEN", 32'(bus.WIN_LEN), 50);
        oor_tap = -1;
        repeat (2) @(posedge clk);

        map_case2();
        set_model();
        @(posedge clk);
        #1;
        bus.START = 1'b1;
        run_active = 1'b1;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        while (run_r < 2 + 40 * P + S + 2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        run_active = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_zero("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run(1'b0);
        chk_case2("rerun");

        for (int t = 0; t < 3; t++) begin
            map_fill(1'b1);
            for (int w = 0; w < 2; w++) begin
                int ws = $urandom_range(0, NT - 2);
                int wl = $urandom_range(1, 30);
                for (int i = ws; i < ws + wl && i < NT; i++) dmap[i] = 1'b0;
            end
            run(t == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
